fetch_unit: RTL and testbench

Front-end instruction fetch stage for the 8-bit processor. Owns the program counter, drives the address into the combinational instruction memory, and captures each fetched instruction with its PC into a 2-entry buffer. The buffer is presented to decode/control through a valid/ready handshake. Supports branch/jump redirect with flush, a halt input, and backpressure.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures {pc, inst} pairs into a 2-entry FIFO and
// presents the head to decode through a valid/ready handshake.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  pc_addr,
    input  logic [7:0]  inst,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_inst,
    output logic [7:0]  out_pc,
    output logic [15:0] issued_count
);

    logic [7:0]  r_pc;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [15:0] r_issued_count;
    logic [7:0]  r_buf_pc   [2];
    logic [7:0]  r_buf_inst [2];

    logic        w_valid;
    logic        w_pop;
    logic        w_full;
    logic        w_fetch;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & out_ready;
    assign w_full  = (r_count == 2'd2);
    // A full buffer may still fetch when the head leaves in the same cycle.
    assign w_fetch = ~redirect & ~halt & (~w_full | w_pop);

    // Buffer storage carries no reset; entries are only observed when counted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_fetch && (r_wr_ptr == 1'(gi))) begin
                    r_buf_pc[gi]   <= r_pc;
                    r_buf_inst[gi] <= inst;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect) begin
            r_pc     <= redirect_addr;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_fetch) begin
                r_pc     <= r_pc + 8'd1;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A pop coinciding with a redirect is still a completed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued_count <= 16'd0;
        end else if (w_pop) begin
            r_issued_count <= r_issued_count + 16'd1;
        end
    end

    assign pc_addr      = r_pc;
    assign out_valid    = w_valid;
    assign out_inst     = w_valid ? r_buf_inst[r_rd_ptr] : 8'h00;
    assign out_pc       = w_valid ? r_buf_pc[r_rd_ptr]   : 8'h00;
    assign issued_count = r_issued_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random phase, checked against
// a queue-based model of the fetch buffer.
module tb_fetch_unit;

    localparam logic [7:0] RPC = 8'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_addr;
    logic [7:0]  inst;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_inst;
    logic [7:0]  out_pc;
    logic [15:0] issued_count;

    logic [7:0]  mem [256];
    assign inst = mem[pc_addr];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .inst(inst),
        .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .issued_count(issued_count)
    );

    // Reference model: queue of {pc, inst} pairs, next PC and handshake count.
    logic [15:0] q [$];
    logic [7:0]  m_pc;
    logic [15:0] m_issued;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] head;
        head = (q.size() != 0) ? q[0] : 16'h0000;
        check("pc_addr", {8'h00, pc_addr}, {8'h00, m_pc});
        check("out_valid", {15'h0, out_valid}, {15'h0, q.size() != 0});
        check("out_pc", {8'h00, out_pc}, {8'h00, head[15:8]});
        check("out_inst", {8'h00, out_inst}, {8'h00, head[7:0]});
        check("issued_count", issued_count, m_issued);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = RPC;
        m_issued = 16'd0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic redir, input logic [7:0] raddr, input logic hlt, input logic rdy);
        logic pop, fetch;
        redirect = redir;
        redirect_addr = raddr;
        halt = hlt;
        out_ready = rdy;
        pop = (q.size() != 0) && rdy;
        fetch = !redir && !hlt && ((q.size() < 2) || pop);
        @(posedge clk);
        #1;
        if (pop) m_issued = m_issued + 16'd1;
        if (redir) begin
            q.delete();
            m_pc = raddr;
        end else begin
            if (pop) void'(q.pop_front());
            if (fetch) begin
                q.push_back({m_pc, mem[m_pc]});
                m_pc = m_pc + 8'd1;
            end
        end
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        reset = 1'b1;
        redirect = 1'b0;
        redirect_addr = 8'h00;
        halt = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset = 1'b0;

        // Stream from reset with a ready consumer.
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure starting at 0x20, then release.
        step(1'b1, 8'h20, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_pc_hold", {8'h00, pc_addr}, 16'h0022);
        check("bp_head", {8'h00, out_pc}, 16'h0020);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Redirect while popping with 0x30/0x31 buffered.
        step(1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h80, 1'b0, 1'b1);
        check("redir_bubble", {15'h0, out_valid}, 16'h0000);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("redir_target", {8'h00, out_pc}, 16'h0080);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // PC wrap, then halt drains the buffer, then resume.
        step(1'b1, 8'hFD, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        check("halt_drained", {15'h0, out_valid}, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // Redirect and halt together: load, flush, stay suspended.
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random phase with random memory contents.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset between edges with a full buffer.
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("full_before_reset", {14'h0, 2'(q.size())}, 16'h0002);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
